gol_generation_sequencer: RTL and testbench
===========================================

Name: gol_generation_sequencer

Overview:
Control FSM for the Game-of-Life demoscene cell-update datapath.
- Decides when a new generation is computed: on a frame-rate divider or a single-step request.
- Sweeps every cell address in row-major order and drives the read and write-back strobes around a fixed-latency neighbour engine.
- Swaps the display and compute buffers when a generation completes, and sequences seed/clear loads of the grid.

Parameters:
GRID_W, 32, grid columns; must be ≥2.
GRID_H, 24, grid rows; must be ≥2.
CALC_LAT, 2, cycles from rd_en to the engine's result for that cell; must be ≥1.
CW, $clog2(GRID_W), column address width (derived).
RW, $clog2(GRID_H), row address width (derived).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse at start of vsync
run  in  1  level; enables free-running generations
step  in  1  one-cycle pulse; compute exactly one generation
seed_req  in  1  one-cycle pulse; load a new grid
speed  in  4  frames per generation minus 1
rd_en  out  1  engine read/compute strobe for cell (rd_row, rd_col)
rd_row  out  RW  row address of current read
rd_col  out  CW  column address of current read
wr_en  out  1  write strobe into the compute buffer
wr_row  out  RW  write row address
wr_col  out  CW  write column address
seed_en  out  1  datapath writes seed_bit instead of the engine result
seed_bit  out  1  seed value for the current write
buf_sel  out  1  display buffer index; compute buffer is ~buf_sel
busy  out  1  high whenever state != IDLE
gen_count  out  16  generations since the last load; wraps

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; frame counter, pending flags and address pipeline cleared.
- States: IDLE, SWEEP, DRAIN, LOAD, SWAP. All outputs registered.
- Frame divider (IDLE only):
  - When run=1, each frame_tick increments fcnt.
  - When the tick arrives with fcnt==speed, it raises the generation trigger and fcnt returns to 0.
  - frame_tick is ignored while busy or while run=0. fcnt is cleared when run=0.
- Pending flags:
  - step or seed_req arriving while busy sets step_p or seed_p. Each flag holds one request; repeats are absorbed.
  - In IDLE, a raw pulse and its pending flag are equivalent.
- IDLE priority, evaluated each cycle:
  1. seed (seed_req or seed_p) → LOAD.
  2. step (step or step_p) → SWEEP.
  3. divider trigger → SWEEP.
  - A consumed flag is cleared on the transition.
  - A simultaneous step and trigger start a single generation.
- SWEEP:
  - Runs GRID_W*GRID_H cycles with rd_en=1.
  - Address starts at (0,0); col increments each cycle and wraps to 0 while row increments.
  - After (GRID_H-1, GRID_W-1) → DRAIN.
- Write-back:
  - wr_en, wr_row and wr_col are rd_en, rd_row and rd_col delayed by exactly CALC_LAT cycles through a shift pipeline.
  - wr_en is never asserted for a cell that was not read.
- DRAIN: lasts CALC_LAT cycles with rd_en=0, then → SWAP. The last wr_en occurs in the final DRAIN cycle.
- SWAP: one cycle; buf_sel toggles, gen_count += 1 (mod 2^16), then → IDLE.
- LOAD:
  - Runs GRID_W*GRID_H cycles with wr_en=1, seed_en=1 and rd_en=0.
  - wr address follows the same row-major sweep, undelayed.
  - Then → SWAP. That SWAP toggles buf_sel and sets gen_count=0.
- Cycle budget per busy interval:
  - Generation: GRID_W*GRID_H + CALC_LAT + 1 busy cycles.
  - Load: GRID_W*GRID_H + 1 busy cycles.
  - busy rises the cycle after the triggering input is sampled.
- run deasserted mid-generation: the generation completes normally.
- rst_n asserted mid-operation: immediate return to reset values. buf_sel=0 and no further swap occurs; the partially written compute buffer is discarded by design.
- Address outputs are held at their last value when their enable is low; checkers ignore them then.

Optional Feature:
GOL_LFSR_SEED_EN
- Defined:
  - A 16-bit Fibonacci LFSR with taps 16,14,13,11 (x^16+x^14+x^13+x^11+1) resets to 16'hACE1.
  - It shifts once per LOAD cycle; seed_bit = lfsr[0] of the current state.
  - The LFSR is not re-seeded between loads, so successive loads produce different grids.
- Undefined: seed_bit is constant 0, so LOAD clears the grid (all cells dead).

Test Plan:
All scenarios use GRID_W=4, GRID_H=3, CALC_LAT=2.
1. Hold rst_n=0 with random inputs → every output 0; release reset with all inputs idle → outputs stay 0 for 20 cycles.
2. run=0, single step pulse → busy high for 15 cycles; rd_en for 12 cycles, addresses (0,0),(0,1)…(2,3); wr_en for 12 cycles starting 2 cycles after the first rd_en with matching addresses; buf_sel 0→1; gen_count=1.
3. run=1, speed=2, frame_tick every 40 cycles → a generation starts only after ticks 3, 6, 9; gen_count=3 after 9 ticks; ticks during busy do not advance the divider.
4. seed_req and step pulsed together during a SWEEP → current generation finishes, then LOAD (12 wr_en with seed_en=1, no rd_en), then a step generation; final gen_count=1, buf_sel toggled 3 times in total.
5. rst_n pulsed low at SWEEP cycle 5 → outputs 0 asynchronously (before the next clock edge); after release, buf_sel=0, gen_count=0, and the next step starts cleanly at (0,0).
6. With GOL_LFSR_SEED_EN, seed_req → first seed_bit=1 and the 12-bit sequence matches a reference LFSR model; without it, all 12 seed_bits are 0.

Source files
------------

// File: rtl/gol_generation_sequencer.sv
// gol_generation_sequencer: control FSM for the Game-of-Life cell-update datapath.
//   Decides when a generation runs (frame divider or single step), sweeps every cell
//   row-major around a CALC_LAT-cycle neighbour engine, swaps buffers and sequences seed loads.
// Ports:
//   frame_tick/run/speed : frame-rate divider (generation every speed+1 frames while run=1)
//   step/seed_req        : one-cycle requests; captured in pending flags while busy
//   rd_*                 : engine read strobe and cell address (held when rd_en=0)
//   wr_*                 : compute-buffer write strobe and address (held when wr_en=0)
//   seed_en/seed_bit     : datapath writes seed_bit instead of the engine result
//   buf_sel              : display buffer index, compute buffer is ~buf_sel
//   busy/gen_count       : FSM not idle / generations since the last load (wraps)
// Optional build macro GOL_LFSR_SEED_EN: seed loads draw cells from a 16-bit LFSR;
//   without it a load clears the grid.
module gol_generation_sequencer #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int CALC_LAT = 2,
  parameter int CW       = $clog2(GRID_W),
  parameter int RW       = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_tick,
  input  logic          run,
  input  logic          step,
  input  logic          seed_req,
  input  logic [3:0]    speed,
  output logic          rd_en,
  output logic [RW-1:0] rd_row,
  output logic [CW-1:0] rd_col,
  output logic          wr_en,
  output logic [RW-1:0] wr_row,
  output logic [CW-1:0] wr_col,
  output logic          seed_en,
  output logic          seed_bit,
  output logic          buf_sel,
  output logic          busy,
  output logic [15:0]   gen_count
);

  localparam logic [RW-1:0] ROW_LAST   = RW'(GRID_H - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(GRID_W - 1);
  localparam int            DW         = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(CALC_LAT - 1);

  typedef enum logic [2:0] {IDLE, SWEEP, DRAIN, LOAD, SWAP} state_t;

  state_t        state;
  logic [3:0]    fcnt;
  logic          step_p;
  logic          seed_p;
  logic          from_load;
  logic [DW-1:0] dcnt;

  // Write-back shift pipeline; the last stage drives the wr_* outputs directly.
  logic          wb_en  [CALC_LAT];
  logic [RW-1:0] wb_row [CALC_LAT];
  logic [CW-1:0] wb_col [CALC_LAT];

  logic seed_go;
  logic step_go;
  logic trig;
  logic load_last;

  assign seed_go   = seed_req | seed_p;
  assign step_go   = step | step_p;
  assign trig      = (state == IDLE) && run && frame_tick && (fcnt == speed);
  assign load_last = (wb_row[CALC_LAT-1] == ROW_LAST) && (wb_col[CALC_LAT-1] == COL_LAST);

  assign wr_en  = wb_en[CALC_LAT-1];
  assign wr_row = wb_row[CALC_LAT-1];
  assign wr_col = wb_col[CALC_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fcnt      <= '0;
      step_p    <= 1'b0;
      seed_p    <= 1'b0;
      from_load <= 1'b0;
      dcnt      <= '0;
      rd_en     <= 1'b0;
      rd_row    <= '0;
      rd_col    <= '0;
      seed_en   <= 1'b0;
      buf_sel   <= 1'b0;
      busy      <= 1'b0;
      gen_count <= '0;
      for (int i = 0; i < CALC_LAT; i++) begin
        wb_en[i]  <= 1'b0;
        wb_row[i] <= '0;
        wb_col[i] <= '0;
      end
    end else begin
      // Addresses only advance with a valid strobe so idle stages hold their last cell.
      wb_en[0] <= rd_en;
      if (rd_en) begin
        wb_row[0] <= rd_row;
        wb_col[0] <= rd_col;
      end
      for (int i = 1; i < CALC_LAT; i++) begin
        wb_en[i] <= wb_en[i-1];
        if (wb_en[i-1]) begin
          wb_row[i] <= wb_row[i-1];
          wb_col[i] <= wb_col[i-1];
        end
      end

      // Divider only counts while idle; dropping run forgets partial progress.
      if (!run) begin
        fcnt <= '0;
      end else if (state == IDLE && frame_tick) begin
        fcnt <= (fcnt == speed) ? '0 : fcnt + 4'd1;
      end

      if (state != IDLE) begin
        if (step)     step_p <= 1'b1;
        if (seed_req) seed_p <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (seed_go) begin
            state     <= LOAD;
            busy      <= 1'b1;
            seed_p    <= 1'b0;
            from_load <= 1'b1;
            seed_en   <= 1'b1;
            // A step arriving alongside the seed runs after the load.
            if (step) step_p <= 1'b1;
            // Loads write undelayed, so they take over the pipeline's output stage.
            wb_en[CALC_LAT-1]  <= 1'b1;
            wb_row[CALC_LAT-1] <= '0;
            wb_col[CALC_LAT-1] <= '0;
          end else if (step_go || trig) begin
            state     <= SWEEP;
            busy      <= 1'b1;
            step_p    <= 1'b0;
            from_load <= 1'b0;
            rd_en     <= 1'b1;
            rd_row    <= '0;
            rd_col    <= '0;
          end
        end

        SWEEP: begin
          if (rd_row == ROW_LAST && rd_col == COL_LAST) begin
            state <= DRAIN;
            rd_en <= 1'b0;
            dcnt  <= '0;
          end else if (rd_col == COL_LAST) begin
            rd_col <= '0;
            rd_row <= rd_row + RW'(1);
          end else begin
            rd_col <= rd_col + CW'(1);
          end
        end

        // Wait for the last in-flight cells to be written back.
        DRAIN: begin
          if (dcnt == DRAIN_LAST) begin
            state <= SWAP;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end

        LOAD: begin
          if (load_last) begin
            state             <= SWAP;
            seed_en           <= 1'b0;
            wb_en[CALC_LAT-1] <= 1'b0;
          end else begin
            wb_en[CALC_LAT-1] <= 1'b1;
            if (wb_col[CALC_LAT-1] == COL_LAST) begin
              wb_col[CALC_LAT-1] <= '0;
              wb_row[CALC_LAT-1] <= wb_row[CALC_LAT-1] + RW'(1);
            end else begin
              wb_col[CALC_LAT-1] <= wb_col[CALC_LAT-1] + CW'(1);
            end
          end
        end

        SWAP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          buf_sel   <= ~buf_sel;
          gen_count <= from_load ? 16'd0 : gen_count + 16'd1;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef GOL_LFSR_SEED_EN
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right; taps land on bits 0,2,3,5.
  // Never re-seeded between loads so consecutive loads give different grids.
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic        seed_bit_q;

  assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign seed_bit = seed_bit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= 16'hACE1;
      seed_bit_q <= 1'b0;
    end else if (state == IDLE && seed_go) begin
      seed_bit_q <= lfsr[0];
    end else if (state == LOAD) begin
      lfsr       <= lfsr_nxt;
      seed_bit_q <= load_last ? 1'b0 : lfsr_nxt[0];
    end
  end
`else
  assign seed_bit = 1'b0;
`endif

endmodule

// File: tb/tb_gol_generation_sequencer.sv
module tb_gol_generation_sequencer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int L  = 2;
  localparam int N  = W * H;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam int GEN_LEN  = N + L + 1;
  localparam int LOAD_LEN = N + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_tick;
  logic          run;
  logic          step;
  logic          seed_req;
  logic [3:0]    speed;
  logic          rd_en;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic          wr_en;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic          seed_en;
  logic          seed_bit;
  logic          buf_sel;
  logic          busy;
  logic [15:0]   gen_count;

  gol_generation_sequencer #(.GRID_W(W), .GRID_H(H), .CALC_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .step(step),
    .seed_req(seed_req), .speed(speed), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .seed_en(seed_en), .seed_bit(seed_bit),
    .buf_sel(buf_sel), .busy(busy), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a busy interval is a timeline indexed by m_t; every output is a
  // plain function of which interval we are in and how far along it is.
  int   m_mode = 0;  // 0 idle, 1 generation, 2 load
  int   m_t    = 0;
  int   m_fcnt = 0;
  bit   m_step_p = 0;
  bit   m_seed_p = 0;
  bit   m_bsel = 0;
  int   m_gcnt = 0;
`ifdef GOL_LFSR_SEED_EN
  int   m_lfsr = 16'hACE1;

  function automatic int lfsr_adv(input int s);
    int fb;
    fb = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
    return ((s >> 1) | (fb << 15)) & 16'hFFFF;
  endfunction
`endif

  always @(posedge clk or negedge rst_n) begin : model
    bit trig;
    if (!rst_n) begin
      m_mode = 0; m_t = 0; m_fcnt = 0; m_step_p = 0; m_seed_p = 0;
      m_bsel = 0; m_gcnt = 0;
`ifdef GOL_LFSR_SEED_EN
      m_lfsr = 16'hACE1;
`endif
    end else if (m_mode == 0) begin
      trig = run && frame_tick && (m_fcnt == int'(speed));
      if (!run) m_fcnt = 0;
      else if (frame_tick) m_fcnt = trig ? 0 : (m_fcnt + 1) % 16;
      if (seed_req || m_seed_p) begin
        m_mode = 2; m_t = 0; m_seed_p = 0;
        if (step) m_step_p = 1;
      end else if (step || m_step_p || trig) begin
        m_mode = 1; m_t = 0; m_step_p = 0;
      end
    end else begin
      if (step) m_step_p = 1;
      if (seed_req) m_seed_p = 1;
      if (!run) m_fcnt = 0;
`ifdef GOL_LFSR_SEED_EN
      if (m_mode == 2 && m_t < N) m_lfsr = lfsr_adv(m_lfsr);
`endif
      m_t++;
      if (m_mode == 1 && m_t == GEN_LEN) begin
        m_mode = 0; m_bsel = ~m_bsel; m_gcnt = (m_gcnt + 1) % 65536;
      end else if (m_mode == 2 && m_t == LOAD_LEN) begin
        m_mode = 0; m_bsel = ~m_bsel; m_gcnt = 0;
      end
    end
  end

  // Observed statistics per scenario.
  int n_rd, n_wr, n_busy, n_seed, n_tog, n_starts, cyc_idx, first_rd, first_wr;
  bit prev_bsel, prev_busy;
  logic [31:0] seed_obs;

  task automatic clr_stats();
    n_rd = 0; n_wr = 0; n_busy = 0; n_seed = 0; n_tog = 0; n_starts = 0;
    cyc_idx = 0; first_rd = -1; first_wr = -1;
    prev_bsel = buf_sel; prev_busy = busy; seed_obs = '0;
  endtask

  function automatic logic [31:0] outs();
    return {2'b0, rd_en, rd_row, rd_col, wr_en, wr_row, wr_col, seed_en, seed_bit,
            buf_sel, busy, gen_count};
  endfunction

  task automatic compare_all();
    logic e_busy, e_rd, e_wr, e_seed, e_sbit;
    int   wa;
    e_busy = (m_mode != 0);
    e_rd   = (m_mode == 1) && (m_t < N);
    e_wr   = ((m_mode == 1) && (m_t >= L) && (m_t < N + L)) || ((m_mode == 2) && (m_t < N));
    wa     = (m_mode == 1) ? m_t - L : m_t;
    e_seed = (m_mode == 2) && (m_t < N);
`ifdef GOL_LFSR_SEED_EN
    e_sbit = e_seed && m_lfsr[0];
`else
    e_sbit = 1'b0;
`endif
    chk("busy", busy, e_busy);
    chk("rd_en", rd_en, e_rd);
    if (e_rd) chk("rd_addr", 32'(rd_row) * W + 32'(rd_col), m_t);
    chk("wr_en", wr_en, e_wr);
    if (e_wr) chk("wr_addr", 32'(wr_row) * W + 32'(wr_col), wa);
    chk("seed_en", seed_en, e_seed);
    chk("seed_bit", seed_bit, e_sbit);
    chk("buf_sel", buf_sel, m_bsel);
    chk("gen_count", gen_count, m_gcnt);

    if (rd_en) begin n_rd++; if (first_rd < 0) first_rd = cyc_idx; end
    if (wr_en) begin n_wr++; if (first_wr < 0) first_wr = cyc_idx; end
    if (busy) n_busy++;
    if (busy && !prev_busy) n_starts++;
    if (seed_en) begin
      if (n_seed < 32) seed_obs[n_seed] = seed_bit;
      n_seed++;
    end
    if (buf_sel != prev_bsel) n_tog++;
    prev_bsel = buf_sel;
    prev_busy = busy;
    cyc_idx++;
  endtask

  task automatic cyc(input bit r, input bit st, input bit sd, input bit ft, input logic [3:0] sp);
    @(negedge clk);
    compare_all();
    run = r; step = st; seed_req = sd; frame_tick = ft; speed = sp;
  endtask

  task automatic idle(input int n, input bit r, input logic [3:0] sp);
    for (int i = 0; i < n; i++) cyc(r, 1'b0, 1'b0, 1'b0, sp);
  endtask

  initial begin
    logic [31:0] exp_seed;
    bit          r;
    logic [3:0]  sp;

    rst_n = 1'b0; run = 0; step = 0; seed_req = 0; frame_tick = 0; speed = 0;

    // 1. Reset held with random inputs, then idle release.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("reset_outs", outs(), 0);
      run = 1'($urandom); step = 1'($urandom); seed_req = 1'($urandom);
      frame_tick = 1'($urandom); speed = 4'($urandom);
    end
    @(negedge clk);
    run = 0; step = 0; seed_req = 0; frame_tick = 0; speed = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("idle_outs", outs(), 0);
    end

    // 2. Single step with run low.
    clr_stats();
    cyc(0, 1, 0, 0, 0);
    idle(24, 0, 0);
    chk("s2_busy_cycles", n_busy, GEN_LEN);
    chk("s2_rd_cycles", n_rd, N);
    chk("s2_wr_cycles", n_wr, N);
    chk("s2_wr_lag", first_wr - first_rd, L);
    chk("s2_buf_sel", buf_sel, 1);
    chk("s2_gen_count", gen_count, 1);

    // 3. Free-running divider, speed=2, plus ticks landing while busy.
    clr_stats();
    for (int k = 1; k <= 9; k++) begin
      cyc(1, 0, 0, 1, 4'd2);
      for (int j = 0; j < 39; j++) cyc(1, 1'b0, 1'b0, (k % 3 == 0) && (j == 5), 4'd2);
    end
    idle(5, 0, 4'd2);
    chk("s3_starts", n_starts, 3);
    chk("s3_gen_count", gen_count, 1 + 3);
    chk("s3_toggles", n_tog, 3);

    // 4. Seed and step together during a sweep.
    clr_stats();
    cyc(0, 1, 0, 0, 0);
    idle(4, 0, 0);
    cyc(0, 1, 1, 0, 0);
    idle(60, 0, 0);
    chk("s4_gen_count", gen_count, 1);
    chk("s4_toggles", n_tog, 3);
    chk("s4_rd_cycles", n_rd, 2 * N);
    chk("s4_wr_cycles", n_wr, 3 * N);
    chk("s4_seed_cycles", n_seed, N);

    // 5. Asynchronous reset in the middle of a sweep.
    cyc(0, 1, 0, 0, 0);
    idle(6, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk("s5_async_reset", outs(), 0);
    @(negedge clk);
    chk("s5_reset_hold", outs(), 0);
    rst_n = 1'b1;
    idle(2, 0, 0);
    chk("s5_buf_sel", buf_sel, 0);
    chk("s5_gen_count", gen_count, 0);
    clr_stats();
    cyc(0, 1, 0, 0, 0);
    idle(20, 0, 0);
    chk("s5_rd_cycles", n_rd, N);
    chk("s5_gen_count_after", gen_count, 1);

    // 6. Seed load contents.
    clr_stats();
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
`ifdef GOL_LFSR_SEED_EN
    chk("s6_first_seed", seed_bit, 1);
    begin
      int s;
      s = 16'hACE1;
      exp_seed = '0;
      for (int i = 0; i < N; i++) begin
        exp_seed[i] = s[0];
        s = lfsr_adv(s);
      end
    end
`else
    chk("s6_first_seed", seed_bit, 0);
    exp_seed = '0;
`endif
    idle(16, 0, 0);
    chk("s6_seed_cycles", n_seed, N);
    chk("s6_seed_bits", seed_obs, exp_seed);
    chk("s6_rd_cycles", n_rd, 0);
    chk("s6_gen_count", gen_count, 0);

    // 7. Randomized traffic against the model.
    r = 0; sp = 4'd1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) r = ~r;
      if ($urandom_range(499) == 0) sp = 4'($urandom_range(3));
      cyc(r, $urandom_range(59) == 0, $urandom_range(199) == 0, $urandom_range(9) == 0, sp);
    end
    idle(40, 0, sp);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
